// File: rtl/debug_unit.sv
// debug_unit: UART command decoder that loads instruction memory, runs/steps the pipeline and streams a state dump.
// Define DEBUG_ACK_EN to send 0x06 after a completed load and 0x15 for an unknown command.
module debug_unit #(
    parameter int NB_IF_ID    = 64,
    parameter int NB_ID_EX    = 168,
    parameter int NB_EX_MEM   = 88,
    parameter int NB_MEM_WB   = 80,
    parameter int N_REGS      = 32,
    parameter int N_MEM_WORDS = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_valid,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_done,
    output logic                 o_stop,
    output logic                 o_write_instruction_mem,
    output logic [31:0]          o_instruction_mem_addr,
    output logic [31:0]          o_instruction_mem_data,
    output logic [4:0]           o_r_addr_registers,
    input  logic [31:0]          i_r_data_registers,
    output logic [31:0]          o_r_addr_data_mem,
    input  logic [31:0]          i_r_data_data_mem,
    input  logic [NB_IF_ID-1:0]  i_IF_ID,
    input  logic [NB_ID_EX-1:0]  i_ID_EX,
    input  logic [NB_EX_MEM-1:0] i_EX_MEM,
    input  logic [NB_MEM_WB-1:0] i_MEM_WB,
    input  logic                 i_end
);
    localparam int NB_LAT = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
    localparam logic [15:0] R_END   = 16'(4 * N_REGS);
    localparam logic [15:0] L_END   = 16'(4 * N_REGS + NB_LAT / 8);
    localparam logic [15:0] TOTAL   = 16'(4 * N_REGS + NB_LAT / 8 + 4 * N_MEM_WORDS);
    localparam logic [15:0] LAT_TOP = 16'(NB_LAT - 8);

    typedef enum logic [3:0] {
        IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP,
        DUMP_ADDR, DUMP_CAP, DUMP_TX, DUMP_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              stop_q, stop_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        k_q, k_d;
    logic [1:0]        nbyte_q, nbyte_d;
    logic [31:0]       word_q, word_d;
    logic [15:0]       idx_q, idx_d;
    logic [NB_LAT-1:0] lat_q, lat_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              single_q, single_d;
    logic              nak_q, nak_d;

    logic [15:0] off, nidx, lidx, lat_shift;
    logic [1:0]  noff, byte_sel;
    logic        in_reg, in_mem, word_start;
    logic [7:0]  dump_byte, tx_byte;

    // Dump byte index spans three regions: register words, latch bytes, memory words.
    always_comb begin
        off        = idx_q - L_END;
        lidx       = idx_q - R_END;
        nidx       = idx_q + 16'd1;
        noff       = nidx[1:0] - L_END[1:0];
        in_reg     = idx_q < R_END;
        in_mem     = idx_q >= L_END;
        byte_sel   = in_reg ? idx_q[1:0] : off[1:0];
        lat_shift  = LAT_TOP - (lidx << 3);
        dump_byte  = (in_reg || in_mem) ? 8'(word_q >> {~byte_sel, 3'b000}) : 8'(lat_q >> lat_shift);
        tx_byte    = single_q ? (nak_q ? 8'h15 : 8'h06) : dump_byte;
        word_start = (nidx < R_END) ? (nidx[1:0] == 2'd0) : (nidx >= L_END && noff == 2'd0);
    end

    always_comb begin
        state_d    = state_q;
        stop_d     = stop_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        nbyte_d    = nbyte_q;
        word_d     = word_q;
        idx_d      = idx_q;
        lat_d      = lat_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        single_d   = single_q;
        nak_d      = nak_q;
        case (state_q)
            IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == 8'h4C) begin
                        state_d = LOAD_CNT;
                    end else if (i_rx_data == 8'h43) begin
                        state_d = RUN;
                        stop_d  = i_end;
                    end else if (i_rx_data == 8'h53) begin
                        state_d = STEP;
                        stop_d  = i_end;
                    end
`ifdef DEBUG_ACK_EN
                    else begin
                        state_d  = DUMP_TX;
                        single_d = 1'b1;
                        nak_d    = 1'b1;
                    end
`endif
                end
            end
            LOAD_CNT: begin
                if (i_rx_valid) begin
                    cnt_d   = i_rx_data;
                    k_d     = 8'd0;
                    nbyte_d = 2'd0;
                    state_d = (i_rx_data == 8'd0) ? IDLE : LOAD_BYTE;
                end
            end
            LOAD_BYTE: begin
                if (i_rx_valid) begin
                    word_d  = {word_q[23:0], i_rx_data};
                    nbyte_d = nbyte_q + 2'd1;
                    state_d = (nbyte_q == 2'd3) ? LOAD_WR : LOAD_BYTE;
                end
            end
            LOAD_WR: begin
                k_d = k_q + 8'd1;
                if (k_d == cnt_q) begin
`ifdef DEBUG_ACK_EN
                    state_d  = DUMP_TX;
                    single_d = 1'b1;
                    nak_d    = 1'b0;
`else
                    state_d  = IDLE;
`endif
                end else begin
                    state_d = LOAD_BYTE;
                end
            end
            RUN: begin
                if (i_end) begin
                    stop_d   = 1'b1;
                    idx_d    = 16'd0;
                    single_d = 1'b0;
                    state_d  = DUMP_ADDR;
                end else begin
                    stop_d = 1'b0;
                end
            end
            STEP: begin
                stop_d   = 1'b1;
                idx_d    = 16'd0;
                single_d = 1'b0;
                state_d  = DUMP_ADDR;
            end
            DUMP_ADDR: begin
                // Pipeline is frozen by now, so one snapshot serves the whole dump.
                if (idx_q == 16'd0) lat_d = {i_IF_ID, i_ID_EX, i_EX_MEM, i_MEM_WB};
                state_d = DUMP_CAP;
            end
            DUMP_CAP: begin
                word_d  = in_reg ? i_r_data_registers : i_r_data_data_mem;
                state_d = DUMP_TX;
            end
            DUMP_TX: begin
                tx_data_d  = tx_byte;
                tx_start_d = 1'b1;
                state_d    = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                if (i_tx_done) begin
                    if (single_q || nidx == TOTAL) begin
                        state_d  = IDLE;
                        single_d = 1'b0;
                    end else begin
                        idx_d   = nidx;
                        state_d = word_start ? DUMP_ADDR : DUMP_TX;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            stop_q     <= 1'b1;
            cnt_q      <= '0;
            k_q        <= '0;
            nbyte_q    <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            lat_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            single_q   <= 1'b0;
            nak_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stop_q     <= stop_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            nbyte_q    <= nbyte_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            lat_q      <= lat_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            single_q   <= single_d;
            nak_q      <= nak_d;
        end
    end

    assign o_stop                  = stop_q;
    assign o_tx_data               = tx_data_q;
    assign o_tx_start              = tx_start_q;
    assign o_write_instruction_mem = (state_q == LOAD_WR);
    assign o_instruction_mem_addr  = {22'd0, k_q, 2'b00};
    assign o_instruction_mem_data  = word_q;
    assign o_r_addr_registers      = in_reg ? idx_q[6:2] : 5'd0;
    assign o_r_addr_data_mem       = in_mem ? {16'd0, off[15:2], 2'b00} : 32'd0;
endmodule
